// File: rtl/line_write_buffer.sv
// line_write_buffer: line-granular write-back FIFO between the cache memory port and main_mem.
// Optional macro WB_COALESCE_EN: a write hitting a buffered line address overwrites it in place.

module line_write_buffer #(
   parameter int unsigned LINE_ADDR_LEN = 3,
   parameter int unsigned ADDR_LEN      = 9,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ADDR_LEN-1:0]               addr,
   input  logic                              rd_req,
   input  logic                              wr_req,
   input  logic [32*(1<<LINE_ADDR_LEN)-1:0]  wr_line,
   output logic [32*(1<<LINE_ADDR_LEN)-1:0]  rd_line,
   output logic                              gnt,
   output logic [ADDR_LEN-1:0]               mem_addr,
   output logic                              mem_rd_req,
   output logic                              mem_wr_req,
   output logic [32*(1<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
   input  logic [32*(1<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
   input  logic                              mem_gnt,
   output logic [$clog2(DEPTH):0]            count,
   output logic                              empty
);

   localparam int unsigned LINE_W = 32 * (1 << LINE_ADDR_LEN);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      MEM_RD,
      MEM_WR,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
   logic [LINE_W-1:0]   rd_line_q, rd_line_d;

   logic [ADDR_LEN-1:0] ent_addr_q [DEPTH];
   logic [ADDR_LEN-1:0] ent_addr_d [DEPTH];
   logic [LINE_W-1:0]   ent_line_q [DEPTH];
   logic [LINE_W-1:0]   ent_line_d [DEPTH];

   logic                match;
   logic [PTR_W-1:0]    match_idx;
   logic [PTR_W-1:0]    scan_idx;
   logic                coal_hit;
   logic                full;

   // Scan oldest to newest so the newest duplicate is the one that sticks.
   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         scan_idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (ent_addr_q[scan_idx] == addr)) begin
            match     = 1'b1;
            match_idx = scan_idx;
         end
      end
   end

`ifdef WB_COALESCE_EN
   assign coal_hit = match;
`else
   assign coal_hit = 1'b0;
`endif

   assign full = (count_q == CNT_W'(DEPTH));

   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      rd_addr_d  = rd_addr_q;
      rd_line_d  = rd_line_q;
      ent_addr_d = ent_addr_q;
      ent_line_d = ent_line_q;

      case (state_q)
         IDLE: begin
            if (rd_req) begin
               if (match) begin
                  rd_line_d = ent_line_q[match_idx];
                  state_d   = RESP;
               end else begin
                  rd_addr_d = addr;
                  state_d   = MEM_RD;
               end
            end else if (wr_req) begin
               if (coal_hit) begin
                  ent_line_d[match_idx] = wr_line;
                  state_d               = RESP;
               end else if (!full) begin
                  ent_addr_d[tail_q] = addr;
                  ent_line_d[tail_q] = wr_line;
                  tail_d             = tail_q + 1'b1;
                  count_d            = count_q + 1'b1;
                  state_d            = RESP;
               end else begin
                  // Request stays pending; it is retried once the head drains.
                  state_d = MEM_WR;
               end
            end else if (count_q != '0) begin
               state_d = MEM_WR;
            end
         end
         MEM_RD: begin
            if (mem_gnt) begin
               rd_line_d = mem_rd_line;
               state_d   = RESP;
            end
         end
         MEM_WR: begin
            if (mem_gnt) begin
               head_d  = head_q + 1'b1;
               count_d = count_q - 1'b1;
               state_d = IDLE;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         rd_addr_q <= '0;
         rd_line_q <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         rd_addr_q <= rd_addr_d;
         rd_line_q <= rd_line_d;
      end
   end

   // Entry payload is deliberately left out of reset.
   always_ff @(posedge clk) begin
      ent_addr_q <= ent_addr_d;
      ent_line_q <= ent_line_d;
   end

   always_comb begin
      mem_addr    = '0;
      mem_wr_line = '0;
      case (state_q)
         MEM_RD: mem_addr = rd_addr_q;
         MEM_WR: begin
            mem_addr    = ent_addr_q[head_q];
            mem_wr_line = ent_line_q[head_q];
         end
         default: begin
            mem_addr    = '0;
            mem_wr_line = '0;
         end
      endcase
   end

   assign gnt        = (state_q == RESP);
   assign mem_rd_req = (state_q == MEM_RD);
   assign mem_wr_req = (state_q == MEM_WR);
   assign rd_line    = rd_line_q;
   assign count      = count_q;
   assign empty      = (count_q == '0);

endmodule

// File: tb/tb_line_write_buffer.sv
// Self-checking bench for line_write_buffer: directed plan steps plus a random phase
// checked against a queue-based model of the buffer and an image of main memory.

module tb_line_write_buffer;

   localparam int unsigned LAL   = 3;
   localparam int unsigned AL    = 9;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned WORDS = 1 << LAL;
   localparam int unsigned LW    = 32 * WORDS;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [AL-1:0] addr;
   logic          rd_req;
   logic          wr_req;
   logic [LW-1:0] wr_line;
   logic [LW-1:0] rd_line;
   logic          gnt;
   logic [AL-1:0] mem_addr;
   logic          mem_rd_req;
   logic          mem_wr_req;
   logic [LW-1:0] mem_wr_line;
   logic [LW-1:0] mem_rd_line;
   logic          mem_gnt;
   logic [CW-1:0] count;
   logic          empty;

   line_write_buffer #(
      .LINE_ADDR_LEN(LAL),
      .ADDR_LEN     (AL),
      .DEPTH        (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .rd_req     (rd_req),
      .wr_req     (wr_req),
      .wr_line    (wr_line),
      .rd_line    (rd_line),
      .gnt        (gnt),
      .mem_addr   (mem_addr),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_wr_line(mem_wr_line),
      .mem_rd_line(mem_rd_line),
      .mem_gnt    (mem_gnt),
      .count      (count),
      .empty      (empty)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AL-1:0] a;
      logic [LW-1:0] d;
   } ent_t;

   ent_t          model[$];
   logic [LW-1:0] mem_img [logic [31:0]];
   int unsigned   checks = 0;
   int unsigned   errors = 0;
   bit            stall = 1'b0;
   int unsigned   mem_lat = 0;
   int unsigned   wait_cnt = 0;
   int unsigned   mem_rd_cnt = 0;
   int unsigned   drain_cnt = 0;
   logic [AL-1:0] cur_addr = '0;
   logic [AL-1:0] last_drain_addr = '0;
   logic [LW-1:0] last_drain_line = '0;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] mem_default(input logic [AL-1:0] a);
      logic [LW-1:0] v;
      for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = {16'hC0DE, 7'h0, a} + 32'(i);
      return v;
   endfunction

   function automatic logic [LW-1:0] mem_fetch(input logic [AL-1:0] a);
      if (mem_img.exists(32'(a))) return mem_img[32'(a)];
      return mem_default(a);
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // What a read of address a must return: newest buffered copy, else memory.
   function automatic logic [LW-1:0] expect_read(input logic [AL-1:0] a);
      logic [LW-1:0] v;
      v = mem_fetch(a);
      foreach (model[i]) if (model[i].a == a) v = model[i].d;
      return v;
   endfunction

   // main_mem stand-in, evaluated once per cycle at the falling edge.
   task automatic serve_mem();
      if (mem_gnt) begin
         mem_gnt  = 1'b0;
         wait_cnt = 0;
      end else if ((mem_rd_req || mem_wr_req) && !stall) begin
         if (wait_cnt < mem_lat) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            mem_gnt  = 1'b1;
            if (mem_rd_req) begin
               mem_rd_cnt++;
               chk("mem_rd_addr", LW'(mem_addr), LW'(cur_addr));
               mem_rd_line = mem_fetch(mem_addr);
            end else begin
               drain_cnt++;
               last_drain_addr = mem_addr;
               last_drain_line = mem_wr_line;
               chk("drain_nonempty", LW'(model.size() != 0), LW'(1));
               if (model.size() != 0) begin
                  chk("drain_addr", LW'(mem_addr), LW'(model[0].a));
                  chk("drain_line", mem_wr_line, model[0].d);
                  void'(model.pop_front());
               end
               mem_img[32'(mem_addr)] = mem_wr_line;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      serve_mem();
   endtask

   task automatic wait_gnt(output int unsigned lat);
      int unsigned n = 0;
      while (!gnt && n < 200) begin
         tick();
         n++;
      end
      chk("gnt_seen", LW'(gnt), LW'(1));
      lat = n + 1;  // the cycle the request is raised counts as cycle 1
   endtask

   task automatic do_write(input logic [AL-1:0] a, input logic [LW-1:0] d, output int unsigned lat);
      int idx = -1;
      addr = a; cur_addr = a; wr_line = d; wr_req = 1'b1;
      wait_gnt(lat);
`ifdef WB_COALESCE_EN
      foreach (model[i]) if (model[i].a == a) idx = i;
`endif
      if (idx >= 0) model[idx].d = d;
      else model.push_back('{a: a, d: d});
      chk("wr_count", LW'(count), LW'(model.size()));
      chk("wr_empty", LW'(empty), LW'(model.size() == 0));
      wr_req = 1'b0;
      tick();
   endtask

   task automatic do_read(input logic [AL-1:0] a, output int unsigned lat);
      addr = a; cur_addr = a; rd_req = 1'b1;
      wait_gnt(lat);
      chk("rd_line", rd_line, expect_read(a));
      rd_req = 1'b0;
      tick();
   endtask

   task automatic wait_empty();
      int unsigned n = 0;
      while (!empty && n < 500) begin
         tick();
         n++;
      end
      chk("drain_to_empty", LW'(empty), LW'(1));
      chk("drain_count0", LW'(count), LW'(0));
   endtask

   initial begin
      int unsigned   lat;
      int unsigned   rd0;
      int unsigned   dr0;
      logic [LW-1:0] ln;
      logic [LW-1:0] lx;
      logic [LW-1:0] ly;
      logic [AL-1:0] ra;

      rst = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_line = '0;
      mem_rd_line = '0; mem_gnt = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_gnt", LW'(gnt), LW'(0));
      chk("rst_mem_rd_req", LW'(mem_rd_req), LW'(0));
      chk("rst_mem_wr_req", LW'(mem_wr_req), LW'(0));
      chk("rst_rd_line", rd_line, LW'(0));
      chk("rst_mem_addr", LW'(mem_addr), LW'(0));
      chk("rst_mem_wr_line", mem_wr_line, LW'(0));
      chk("rst_count", LW'(count), LW'(0));
      chk("rst_empty", LW'(empty), LW'(1));

      // 1: single write, then background drain
      for (int i = 0; i < WORDS; i++) ln[i*32 +: 32] = 32'(i);
      do_write(9'h012, ln, lat);
      chk("t1_wr_lat", LW'(lat), LW'(2));
      wait_empty();
      chk("t1_drain_addr", LW'(last_drain_addr), LW'(9'h012));
      chk("t1_drain_line", last_drain_line, ln);

      // 2: read hit served from the buffer
      rd0 = mem_rd_cnt;
      do_write(9'h030, {WORDS{32'hA5A5A5A5}}, lat);
      do_read(9'h030, lat);
      chk("t2_rd_lat", LW'(lat), LW'(2));
      chk("t2_no_mem_rd", LW'(mem_rd_cnt), LW'(rd0));
      wait_empty();

      // 3: read miss forwarded to main_mem
      mem_img[32'(9'h1FF)] = {WORDS{32'hDEADBEEF}};
      mem_lat = 2;
      rd0 = mem_rd_cnt;
      do_read(9'h1FF, lat);
      chk("t3_rd_data", rd_line, {WORDS{32'hDEADBEEF}});
      chk("t3_mem_rd", LW'(mem_rd_cnt), LW'(rd0 + 1));
      // sample, MEM_RD entry, mem_lat waits, grant edge, RESP
      chk("t3_rd_lat", LW'(lat), LW'(mem_lat + 3));
      mem_lat = 0;

      // 4: fill while main_mem stalls, fifth write forces one drain
      stall = 1'b1;
      dr0 = drain_cnt;
      for (int i = 0; i < 4; i++) begin
         do_write(AL'(9'h100 + i), rand_line(), lat);
         chk("t4_wr_lat", LW'(lat), LW'(2));
      end
      chk("t4_full_count", LW'(count), LW'(4));
      ln = rand_line();
      addr = 9'h104; cur_addr = 9'h104; wr_line = ln; wr_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_full_no_gnt", LW'(gnt), LW'(0));
         chk("t4_full_drain_req", LW'(mem_wr_req), LW'(1));
         chk("t4_full_drain_head", LW'(mem_addr), LW'(9'h100));
      end
      stall = 1'b0;
      wait_gnt(lat);
      model.push_back('{a: 9'h104, d: ln});
      chk("t4_after_accept_count", LW'(count), LW'(4));
      chk("t4_one_drain", LW'(drain_cnt), LW'(dr0 + 1));
      wr_req = 1'b0;
      tick();
      wait_empty();
      chk("t4_all_drained", LW'(drain_cnt), LW'(dr0 + 5));
      chk("t4_last_drain", LW'(last_drain_addr), LW'(9'h104));

      // 5: two writes to one address
      lx = rand_line();
      ly = rand_line();
      dr0 = drain_cnt;
      do_write(9'h040, lx, lat);
      do_write(9'h040, ly, lat);
`ifdef WB_COALESCE_EN
      chk("t5_count", LW'(count), LW'(1));
`else
      chk("t5_count", LW'(count), LW'(2));
`endif
      do_read(9'h040, lat);
      chk("t5_rd_newest", rd_line, ly);
      wait_empty();
`ifdef WB_COALESCE_EN
      chk("t5_drains", LW'(drain_cnt), LW'(dr0 + 1));
`else
      chk("t5_drains", LW'(drain_cnt), LW'(dr0 + 2));
`endif
      chk("t5_last_line", last_drain_line, ly);

      // 6: reset while a drain is in flight
      stall = 1'b1;
      for (int i = 0; i < 3; i++) do_write(AL'(9'h201 + i), rand_line(), lat);
      tick();
      tick();
      chk("t6_in_mem_wr", LW'(mem_wr_req), LW'(1));
      chk("t6_count3", LW'(count), LW'(3));
      rst = 1'b1;
      tick();
      chk("t6_rst_count", LW'(count), LW'(0));
      chk("t6_rst_mem_wr_req", LW'(mem_wr_req), LW'(0));
      chk("t6_rst_gnt", LW'(gnt), LW'(0));
      chk("t6_rst_empty", LW'(empty), LW'(1));
      chk("t6_rst_mem_addr", LW'(mem_addr), LW'(0));
      rst = 1'b0;
      model.delete();
      stall = 1'b0;
      wait_cnt = 0;
      do_write(9'h205, rand_line(), lat);
      chk("t6_post_rst_lat", LW'(lat), LW'(2));
      wait_empty();

      // random mix over a small address pool so hits and duplicates are common
      for (int n = 0; n < 300; n++) begin
         mem_lat = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 0) begin
            do_write(AL'(9'h0A0 + $urandom_range(0, 5)), rand_line(), lat);
         end else begin
            if ($urandom_range(0, 4) == 0) ra = AL'(9'h150 + $urandom_range(0, 15));
            else ra = AL'(9'h0A0 + $urandom_range(0, 5));
            do_read(ra, lat);
         end
         for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      end
      wait_empty();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
